fetch_queue_param: RTL and testbench
====================================

// Module: fetch_queue_param
// PURPOSE
//  Parametrised instruction-fetch front end for the pipelined RISC-V core; replaces the bare PC flop + fixed IF/ID register.
//  Owns the PC, drives the instruction ROM address, buffers {pc, instr} pairs in a DEPTH-entry circular queue.
//  Decode drains the queue with a valid/ready handshake; a branch/jump redirect from execute flushes it and reloads the PC.
//  Decouples decode stalls from fetch without losing or duplicating instructions.
// PARAMETERS
//  DATA_WIDTH  32            instruction width
//  ADDR_WIDTH  32            PC / ROM address width
//  DEPTH       4             queue entries; power of 2, >= 2
//  RESET_PC    32'h0040_0000 PC loaded by reset
//  PC_STEP     4             PC increment per fetched instruction
// PORTS
//  i_clk          in   1                  core clock, all state on rising edge
//  i_rst          in   1                  synchronous reset, active-high
//  i_fetch_en     in   1                  fetch permitted (tie to pll_lock); 0 = no new fetches, queue still drains
//  o_imem_addr    out  ADDR_WIDTH         ROM address (= current PC)
//  i_imem_rdata   in   DATA_WIDTH         ROM read data, combinational from o_imem_addr
//  i_redirect     in   1                  taken branch / jal / jalr from execute
//  i_redirect_pc  in   ADDR_WIDTH         redirect target
//  o_deq_valid    out  1                  queue head valid
//  i_deq_ready    in   1                  decode accepts head
//  o_deq_instr    out  DATA_WIDTH         head instruction
//  o_deq_pc       out  ADDR_WIDTH         head PC
//  o_deq_pc_plus  out  ADDR_WIDTH         head PC + PC_STEP (link value for jal/jalr)
//  o_count        out  $clog2(DEPTH)+1    current occupancy
// BEHAVIOUR
//  Reset (i_rst=1 at edge): pc=RESET_PC, wr_ptr=rd_ptr=0, count=0; o_deq_valid=0, o_count=0, o_imem_addr=RESET_PC.
//  Reset has priority over every other input, including mid-operation redirect; queue contents are discarded.
//  full = (count==DEPTH); empty = (count==0); o_deq_valid = ~empty.
//  pop  = o_deq_valid & i_deq_ready & ~i_redirect.
//  push = i_fetch_en & ~i_redirect & (~full | pop)   -- push into a full queue is allowed only with a same-cycle pop.
//  push: mem[wr_ptr] <= {o_imem_addr, i_imem_rdata}; wr_ptr+1 (wraps mod DEPTH); pc <= pc + PC_STEP (mod 2^ADDR_WIDTH).
//  pop: rd_ptr+1 (wraps mod DEPTH). count: +1 on push only, -1 on pop only, unchanged on both or neither.
//  No push: pc holds. Pointers are $clog2(DEPTH) bits; natural wrap, no explicit compare.
//  Redirect (wins over push/pop): wr_ptr=rd_ptr=0, count=0, pc <= {i_redirect_pc[ADDR_WIDTH-1:2], 2'b00}.
//  A handshake that coincides with redirect is not a pop; that head entry is discarded with the rest.
//  Latency: fetch at cycle N -> visible at queue head N+1 when the queue is empty.
//  Redirect sampled at N -> o_imem_addr=target at N+1 -> o_deq_valid=1 with target instr at N+2.
//  o_deq_instr/o_deq_pc come from mem[rd_ptr]; value is don't-care when o_deq_valid=0; o_deq_pc_plus = o_deq_pc + PC_STEP.
//  o_deq_* are stable while o_deq_valid=1 and i_deq_ready=0 (hold until accepted or flushed).
//  i_fetch_en low: no push, pc frozen; pops continue normally.
//  Queue order is strictly FIFO; no entry is lost or duplicated across full/empty boundaries or pointer wrap.
// TESTING
//  1 Reset, fetch_en=1, ready=1 each cycle -> deq pc 0x00400000, 0x00400004, 0x00400008 on successive cycles; count stays 1.
//  2 ready=0 for 8 cycles (DEPTH=4) -> count saturates at 4, o_imem_addr holds 0x00400010.
//    Then ready=1 -> pops 0x00400000..0x0040000C in order, no gap at full.
//  3 Full queue, ready=1 for 2*DEPTH cycles -> push+pop each cycle, count stays 4, pc sequence continuous through pointer wrap.
//  4 Queue holds 3 entries, redirect to 0x00400103 with ready=1 -> next cycle count=0, o_deq_valid=0, o_imem_addr=0x00400100.
//    Cycle after: head pc=0x00400100; discarded entries never appear.
//  5 fetch_en=0 with 2 entries queued, ready=1 -> both drain, count=0, o_imem_addr frozen.
//    fetch_en back to 1 -> fetch resumes at the frozen address.
//  6 i_rst asserted with full queue and redirect pending -> next cycle count=0, o_deq_valid=0, o_imem_addr=0x00400000.

Source files
------------

// File: rtl/fetch_queue_param.sv
// Purpose: instruction-fetch front end; owns the PC and buffers {pc, instr} pairs in a DEPTH-entry FIFO.
// Latency: fetch at N is visible at the queue head at N+1; a redirect at N puts the target on the head at N+2.
// Backpressure: decode stalls via i_deq_ready=0; the queue fills, then the PC freezes until a slot frees.
//
// Ports:
//   i_clk, i_rst              clock / synchronous active-high reset
//   i_fetch_en                fetch permitted; low freezes the PC, the queue still drains
//   o_imem_addr, i_imem_rdata ROM address (= PC) and its combinational read data
//   i_redirect, i_redirect_pc taken branch / jump from execute and its target
//   o_deq_valid, i_deq_ready  head handshake toward decode
//   o_deq_instr, o_deq_pc     head entry contents
//   o_deq_pc_plus             head PC + PC_STEP (link value)
//   o_count                   current occupancy
module fetch_queue_param #(
    parameter int unsigned             DATA_WIDTH = 32,
    parameter int unsigned             ADDR_WIDTH = 32,
    parameter int unsigned             DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0]   RESET_PC   = 32'h0040_0000,
    parameter int unsigned             PC_STEP    = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_fetch_en,
    output logic [ADDR_WIDTH-1:0]         o_imem_addr,
    input  logic [DATA_WIDTH-1:0]         i_imem_rdata,
    input  logic                          i_redirect,
    input  logic [ADDR_WIDTH-1:0]         i_redirect_pc,
    output logic                          o_deq_valid,
    input  logic                          i_deq_ready,
    output logic [DATA_WIDTH-1:0]         o_deq_instr,
    output logic [ADDR_WIDTH-1:0]         o_deq_pc,
    output logic [ADDR_WIDTH-1:0]         o_deq_pc_plus,
    output logic [$clog2(DEPTH):0]        o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] instr;
    } entry_t;

    // Redirect targets are forced word-aligned by clearing the low two bits.
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] pc_q,     pc_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q,  count_d;
    entry_t                mem_q [DEPTH];

    logic   full;
    logic   empty;
    logic   push;
    logic   pop;
    entry_t head;
    entry_t wr_entry;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    always_comb begin
        full  = (count_q == CNT_W'(DEPTH));
        empty = (count_q == '0);
        // A handshake in the redirect cycle does not consume the head: the
        // whole queue, head included, is being thrown away.
        pop   = ~empty & i_deq_ready & ~i_redirect;
        // A full queue may still accept a fetch when the head leaves in the
        // same cycle, so a continuously-ready decoder sees no bubble at full.
        push  = i_fetch_en & ~i_redirect & (~full | pop);
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (i_redirect) begin
            pc_d     = i_redirect_pc & ALIGN_MASK;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                pc_d     = pc_q + ADDR_WIDTH'(PC_STEP);
                // Pointer width is log2(DEPTH), so the increment wraps naturally.
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc_q     <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Entry storage. Contents need no reset: occupancy alone decides what
    // is valid, and a reset or redirect simply forgets every entry.
    // ------------------------------------------------------------------
    always_comb begin
        wr_entry.pc    = pc_q;
        wr_entry.instr = i_imem_rdata;
    end

    always_ff @(posedge i_clk) begin
        if (push && !i_rst) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        head          = mem_q[rd_ptr_q];
        o_imem_addr   = pc_q;
        o_deq_valid   = ~empty;
        o_deq_instr   = head.instr;
        o_deq_pc      = head.pc;
        o_deq_pc_plus = head.pc + ADDR_WIDTH'(PC_STEP);
        o_count       = count_q;
    end

endmodule

// File: tb/tb_fetch_queue_param.sv
// Purpose: self-checking bench for fetch_queue_param against a queue-based reference model.
// Latency: one model step per clock; outputs are sampled on the falling edge.
// Backpressure: decode readiness is driven directly (directed scenarios, then random).
module tb_fetch_queue_param;

    localparam int DEPTH = 4;
    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic        i_clk = 1'b0;
    logic        i_rst, i_fetch_en, i_redirect, i_deq_ready;
    logic [31:0] o_imem_addr, i_imem_rdata, i_redirect_pc;
    logic        o_deq_valid;
    logic [31:0] o_deq_instr, o_deq_pc, o_deq_pc_plus;
    logic [2:0]  o_count;

    int total = 0;
    int bad   = 0;

    always #5 i_clk = ~i_clk;

    // ROM contents: a fixed scramble of the address so every word is distinct.
    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    assign i_imem_rdata = rom(o_imem_addr);

    fetch_queue_param dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_fetch_en    (i_fetch_en),
        .o_imem_addr   (o_imem_addr),
        .i_imem_rdata  (i_imem_rdata),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_deq_valid   (o_deq_valid),
        .i_deq_ready   (i_deq_ready),
        .o_deq_instr   (o_deq_instr),
        .o_deq_pc      (o_deq_pc),
        .o_deq_pc_plus (o_deq_pc_plus),
        .o_count       (o_count)
    );

    // Reference model: a queue of fetched PCs plus the model PC.
    logic [31:0] mq[$];
    logic [31:0] m_pc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("count", 64'(o_count), 64'(mq.size()));
        chk("valid", 64'(o_deq_valid), 64'(mq.size() != 0));
        chk("imem_addr", 64'(o_imem_addr), 64'(m_pc));
        if (mq.size() != 0) begin
            chk("deq_pc",    64'(o_deq_pc),      64'(mq[0]));
            chk("deq_instr", 64'(o_deq_instr),   64'(rom(mq[0])));
            chk("deq_plus",  64'(o_deq_pc_plus), 64'(mq[0] + 32'd4));
        end
    endtask

    // Apply one cycle of inputs, advance the model by the rules, then check after the edge.
    task automatic cyc(input logic rst, input logic fe, input logic rd,
                       input logic [31:0] rpc, input logic rdy);
        bit do_pop, do_push;
        i_rst = rst; i_fetch_en = fe; i_redirect = rd;
        i_redirect_pc = rpc; i_deq_ready = rdy;
        if (rst) begin
            mq.delete();
            m_pc = RST_PC;
        end else if (rd) begin
            mq.delete();
            m_pc = {rpc[31:2], 2'b00};
        end else begin
            do_pop  = (mq.size() != 0) && rdy;
            do_push = fe && ((mq.size() < DEPTH) || do_pop);
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                mq.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
        end
        @(negedge i_clk);
        check_outputs();
    endtask

    initial begin
        m_pc = RST_PC;
        i_rst = 1'b1; i_fetch_en = 1'b0; i_redirect = 1'b0;
        i_redirect_pc = '0; i_deq_ready = 1'b0;
        @(negedge i_clk);

        // 1: streaming with decode always ready
        cyc(1, 0, 0, 0, 0);
        chk("rst_addr",  64'(o_imem_addr), 64'(RST_PC));
        chk("rst_valid", 64'(o_deq_valid), 64'd0);
        chk("rst_count", 64'(o_count), 64'd0);
        for (int k = 0; k < 4; k++) begin
            cyc(0, 1, 0, 0, 1);
            chk("t1_pc",    64'(o_deq_pc), 64'(RST_PC + 32'(4 * k)));
            chk("t1_count", 64'(o_count), 64'd1);
        end

        // 2: stall until full, then drain in order
        cyc(1, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++) cyc(0, 1, 0, 0, 0);
        chk("t2_count", 64'(o_count), 64'd4);
        chk("t2_addr",  64'(o_imem_addr), 64'h0040_0010);
        chk("t2_head",  64'(o_deq_pc), 64'h0040_0000);

        // 3: full queue with push+pop each cycle through pointer wrap
        for (int k = 0; k < 2 * DEPTH; k++) begin
            cyc(0, 1, 0, 0, 1);
            chk("t3_count", 64'(o_count), 64'd4);
            chk("t3_pc",    64'(o_deq_pc), 64'(32'h0040_0004 + 32'(4 * k)));
        end

        // 4: redirect with three entries queued
        cyc(1, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) cyc(0, 1, 0, 0, 0);
        chk("t4_pre", 64'(o_count), 64'd3);
        cyc(0, 1, 1, 32'h0040_0103, 1);
        chk("t4_count", 64'(o_count), 64'd0);
        chk("t4_valid", 64'(o_deq_valid), 64'd0);
        chk("t4_addr",  64'(o_imem_addr), 64'h0040_0100);
        cyc(0, 1, 0, 0, 0);
        chk("t4_head",  64'(o_deq_pc), 64'h0040_0100);

        // 5: fetch disabled drains the queue and freezes the PC
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        chk("t5_count", 64'(o_count), 64'd0);
        chk("t5_addr",  64'(o_imem_addr), 64'h0040_0008);
        cyc(0, 1, 0, 0, 0);
        chk("t5_head",  64'(o_deq_pc), 64'h0040_0008);

        // 6: reset beats a pending redirect on a full queue
        for (int k = 0; k < 5; k++) cyc(0, 1, 0, 0, 0);
        chk("t6_full", 64'(o_count), 64'd4);
        cyc(1, 1, 1, 32'h1234_5678, 1);
        chk("t6_count", 64'(o_count), 64'd0);
        chk("t6_valid", 64'(o_deq_valid), 64'd0);
        chk("t6_addr",  64'(o_imem_addr), 64'(RST_PC));

        // Random traffic against the model
        for (int k = 0; k < 3000; k++) begin
            logic r_rst, r_fe, r_rd, r_rdy;
            logic [31:0] r_pc;
            r_rst = ($urandom_range(0, 199) == 0);
            r_rd  = ($urandom_range(0, 24) == 0);
            r_fe  = ($urandom_range(0, 3) != 0);
            r_rdy = ($urandom_range(0, 2) != 0);
            r_pc  = $urandom;
            cyc(r_rst, r_fe, r_rd, r_pc, r_rdy);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
